fp_mul_unpack: RTL

Front-end input stage of the pipelined floating-point multiplier. It accepts an operand pair over a valid/ready handshake and decodes each operand into sign, significand with hidden bit, and a special-case class code. It also computes the biased exponent sum and presents the result to the downstream mantissa-multiply stages. A 2-entry skid buffer (output register plus skid register) gives registered ready/valid and full throughput.

---
 rtl/fp_mul_unpack.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/fp_mul_unpack.sv
// Front-end of the pipelined FP multiplier: decodes an operand pair into sign,
// significands, class codes and biased exponent sum behind a 2-entry skid buffer.
module fp_mul_unpack #(
  parameter int DW   = 16,
  parameter int EXP  = 5,
  parameter int MANT = 10,
  parameter int BIAS = (2**(EXP-1))-1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DW-1:0]         op_a,
  input  logic [DW-1:0]         op_b,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  sign_out,
  output logic signed [EXP+1:0] exp_sum,
  output logic [MANT:0]         mant_a,
  output logic [MANT:0]         mant_b,
  output logic [2:0]            spe_case_a,
  output logic [2:0]            spe_case_b
);

  localparam logic [2:0] CLS_NORMAL = 3'd0;
  localparam logic [2:0] CLS_DENORM = 3'd1;
  localparam logic [2:0] CLS_ZERO   = 3'd2;
  localparam logic [2:0] CLS_INF    = 3'd3;
  localparam logic [2:0] CLS_NAN    = 3'd4;

  localparam logic [EXP+1:0] BIAS_W = (EXP+2)'(BIAS);

  typedef enum logic [1:0] {EMPTY, ONE, FULL} state_e;

  typedef struct packed {
    logic           sign;
    logic [EXP+1:0] exp_sum;
    logic [MANT:0]  mant_a;
    logic [MANT:0]  mant_b;
    logic [2:0]     cls_a;
    logic [2:0]     cls_b;
  } beat_t;

  function automatic logic [2:0] classify(input logic [EXP-1:0] e, input logic [MANT-1:0] f);
    logic [2:0] cls;
    if (&e)            cls = (f == '0) ? CLS_INF  : CLS_NAN;
    else if (e == '0)  cls = (f == '0) ? CLS_ZERO : CLS_DENORM;
    else               cls = CLS_NORMAL;
    return cls;
  endfunction

  // Denormals share the exponent of the smallest normal, hence exp==0 maps to 1.
  function automatic logic [EXP+1:0] eff_exp(input logic [EXP-1:0] e);
    return (e == '0) ? (EXP+2)'(1) : (EXP+2)'(e);
  endfunction

  logic [EXP-1:0]  exp_a, exp_b;
  logic [MANT-1:0] frac_a, frac_b;
  beat_t           in_beat;

  assign exp_a  = op_a[DW-2 -: EXP];
  assign exp_b  = op_b[DW-2 -: EXP];
  assign frac_a = op_a[MANT-1:0];
  assign frac_b = op_b[MANT-1:0];

  always_comb begin
    in_beat.sign    = op_a[DW-1] ^ op_b[DW-1];
    in_beat.exp_sum = eff_exp(exp_a) + eff_exp(exp_b) - BIAS_W;
    in_beat.mant_a  = {|exp_a, frac_a};
    in_beat.mant_b  = {|exp_b, frac_b};
    in_beat.cls_a   = classify(exp_a, frac_a);
    in_beat.cls_b   = classify(exp_b, frac_b);
  end

  state_e state_q, state_d;
  beat_t  out_q, out_d;
  beat_t  skid_q, skid_d;
  logic   push, pop;

  // Handshake flags derive only from the state register, so in_ready never
  // sees out_ready combinationally.
  always_comb begin
    out_valid = (state_q != EMPTY);
    in_ready  = (state_q != FULL);
  end

  assign push = in_valid && in_ready;
  assign pop  = out_valid && out_ready;

  // NOTE: every target gets a default before the case so no path leaves a
  // variable unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    skid_d  = skid_q;
    unique case (state_q)
      EMPTY: begin
        if (push) begin
          out_d   = in_beat;
          state_d = ONE;
        end
      end
      ONE: begin
        if (push && pop) begin
          out_d = in_beat;
        end else if (pop) begin
          state_d = EMPTY;
        end else if (push) begin
          skid_d  = in_beat;
          state_d = FULL;
        end
      end
      FULL: begin
        if (pop) begin
          out_d   = skid_q;
          state_d = ONE;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  // NOTE: state uses non-blocking assignments so every flop samples the
  // pre-edge values; the data registers are reset too since they drive ports.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      out_q   <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      skid_q  <= skid_d;
    end
  end

  assign sign_out   = out_q.sign;
  assign exp_sum    = out_q.exp_sum;
  assign mant_a     = out_q.mant_a;
  assign mant_b     = out_q.mant_b;
  assign spe_case_a = out_q.cls_a;
  assign spe_case_b = out_q.cls_b;

endmodule
